fx_arb: RTL and testbench

- Two-master arbiter for the shared fx register bus (22-bit address, 8-bit data; bits [21:16] select the device, [15:0] the register).
- Master 0 is the host-interface bridge; master 1 is the internal config sequencer (e.g. loads threshold/timing registers after boot).
- Serialises their single-byte read/write transactions onto one fx bus with round-robin fairness, and returns read data and a completion ack to the owning master.

---
 rtl/fx_bus_pkg.sv | 32 +++
 rtl/fx_arb_if.sv | 40 ++++
 rtl/fx_rr2.sv | 20 ++
 rtl/fx_arb.sv | 146 ++++++++++++++
 tb/tb_fx_arb.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg -- shared definitions for the fx register bus arbiter.
//   AW/DW       : fx address / data widths
//   fx_state_e  : arbiter FSM encoding (IDLE=0, XFER=1, WAIT=2, ACK=3)
//   fx_req_t    : one master's transaction (we/addr/wdata)
//   fx_dev()    : device-id field of an fx address ([21:16]); [15:0] is the register
package fx_bus_pkg;

   localparam int AW     = 22;
   localparam int DW     = 8;
   localparam int DEV_HI = 21;
   localparam int DEV_LO = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WAIT = 2'd2,
      S_ACK  = 2'd3
   } fx_state_e;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } fx_req_t;

   typedef logic [DEV_HI-DEV_LO:0] fx_dev_t;

   function automatic fx_dev_t fx_dev(input logic [AW-1:0] addr);
      return addr[DEV_HI:DEV_LO];
   endfunction

endpackage

// File: rtl/fx_arb_if.sv
// fx_arb_if -- bundle of both master handshakes and the shared fx bus.
//   m<n>_req/we/addr/wdata : master n transaction request, held until m<n>_ack
//   m<n>_ack/rdata         : one-cycle completion pulse and read data
//   fx_wr/fx_waddr/fx_data : write strobe and write address/data to the slaves
//   fx_rd/fx_raddr/fx_q    : read strobe, read address and OR-combined read data
//   busy/gnt               : arbiter status
// Modports: slave = the arbiter's view, master = masters plus slave devices.
interface fx_arb_if;
   import fx_bus_pkg::*;

   logic          m0_req, m0_we, m0_ack;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_ack;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          fx_wr, fx_rd;
   logic [AW-1:0] fx_waddr, fx_raddr;
   logic [DW-1:0] fx_data, fx_q;
   logic          busy, gnt;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  fx_q,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
      output busy, gnt
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output fx_q,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
      input  busy, gnt
   );

endinterface

// File: rtl/fx_rr2.sv
// fx_rr2 -- combinational 2-way round-robin pick.
//   req0_i, req1_i : requests
//   last_gnt_i     : index granted last time
//   valid_o        : some request is pending
//   idx_o          : winner; on a tie the master that was not granted last
module fx_rr2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_gnt_i,
   output logic valid_o,
   output logic idx_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i) idx_o = ~last_gnt_i;
      else                  idx_o = req1_i;
   end

endmodule

// File: rtl/fx_arb.sv
// fx_arb -- two-master round-robin arbiter for the fx register bus.
// Serialises single-byte reads/writes from master 0 (host bridge) and master 1
// (config sequencer) onto one fx bus and returns ack/rdata to the owner.
//   clk_sys : system clock
//   rst     : synchronous reset, active-high (aborts any transaction)
//   bus     : fx_arb_if.slave -- master handshakes, fx strobes/addr/data, busy, gnt
// Parameter RD_LAT (1..7): cycles from the fx_rd pulse until fx_q is valid.
module fx_arb
   import fx_bus_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic   clk_sys,
   input  logic   rst,
   fx_arb_if.slave bus
);

   // WAIT spends RD_LAT cycles: the counter starts at RD_LAT-1 and fx_q is
   // captured in the cycle it reads zero.
   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   fx_state_e           state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic                gnt_q, gnt_d;
   logic                fx_wr_q, fx_wr_d;
   logic                fx_rd_q, fx_rd_d;
   logic [AW-1:0]       fx_waddr_q, fx_waddr_d;
   logic [AW-1:0]       fx_raddr_q, fx_raddr_d;
   logic [DW-1:0]       fx_data_q, fx_data_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [1:0]          ack_q, ack_d;
   logic [1:0][DW-1:0]  rdata_q, rdata_d;

   fx_req_t req0, req1, win;
   logic    pick_vld, pick_idx;

   assign req0 = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
   assign req1 = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};

   fx_rr2 u_rr (
      .req0_i     (bus.m0_req),
      .req1_i     (bus.m1_req),
      .last_gnt_i (last_gnt_q),
      .valid_o    (pick_vld),
      .idx_o      (pick_idx)
   );

   assign win = pick_idx ? req1 : req0;

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      fx_wr_d    = 1'b0;
      fx_rd_d    = 1'b0;
      fx_waddr_d = fx_waddr_q;
      fx_raddr_d = fx_raddr_q;
      fx_data_d  = fx_data_q;
      cnt_d      = cnt_q;
      ack_d      = 2'b00;
      rdata_d    = rdata_q;
      case (state_q)
         S_IDLE: begin
            // Strobes are registered here so they are high for the XFER cycle;
            // the address/data register of the other direction keeps its value.
            if (pick_vld) begin
               gnt_d = pick_idx;
               if (win.we) begin
                  fx_wr_d    = 1'b1;
                  fx_waddr_d = win.addr;
                  fx_data_d  = win.wdata;
               end else begin
                  fx_rd_d    = 1'b1;
                  fx_raddr_d = win.addr;
               end
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            // fx_wr_q is high in XFER exactly when the granted op is a write.
            if (fx_wr_q) begin
               ack_d[gnt_q] = 1'b1;
               state_d      = S_ACK;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               rdata_d[gnt_q] = bus.fx_q;
               ack_d[gnt_q]   = 1'b1;
               state_d        = S_ACK;
            end
         end
         S_ACK: begin
            last_gnt_d = gnt_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q    <= S_IDLE;
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
         fx_waddr_q <= '0;
         fx_raddr_q <= '0;
         fx_data_q  <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         fx_wr_q    <= fx_wr_d;
         fx_rd_q    <= fx_rd_d;
         fx_waddr_q <= fx_waddr_d;
         fx_raddr_q <= fx_raddr_d;
         fx_data_q  <= fx_data_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.m0_ack   = ack_q[0];
   assign bus.m1_ack   = ack_q[1];
   assign bus.m0_rdata = rdata_q[0];
   assign bus.m1_rdata = rdata_q[1];
   assign bus.fx_wr    = fx_wr_q;
   assign bus.fx_rd    = fx_rd_q;
   assign bus.fx_waddr = fx_waddr_q;
   assign bus.fx_raddr = fx_raddr_q;
   assign bus.fx_data  = fx_data_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.gnt      = gnt_q;

endmodule

// File: tb/tb_fx_arb.sv
// tb_fx_arb -- scoreboard bench for fx_arb. Two instances (RD_LAT=1 and 3)
// share one stimulus set; dsel routes requests to, and observes, one of them.
`timescale 1ns/1ps
module tb_fx_arb;
   import fx_bus_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   logic dsel = 1'b0;
   int   rdlat;
   assign rdlat = dsel ? 3 : 1;

   logic [1:0]    m_req = 2'b00;
   logic [1:0]    m_we  = 2'b00;
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_wd   [2];

   // observed (selected) DUT outputs
   logic [1:0]          o_ack0, o_ack1, o_wr, o_rd, o_busy, o_gnt;
   logic [1:0][DW-1:0]  o_rd0, o_rd1, o_data;
   logic [1:0][AW-1:0]  o_waddr, o_raddr;
   logic                m0_ack, m1_ack, fx_wr, fx_rd, busy, gnt;
   logic [DW-1:0]       m0_rdata, m1_rdata, fx_data, fx_q;
   logic [AW-1:0]       fx_waddr, fx_raddr;
   logic [1:0]          acks;

   for (genvar g = 0; g < 2; g++) begin : gd
      fx_arb_if bus ();
      fx_arb #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
         .clk_sys (clk),
         .rst     (rst),
         .bus     (bus.slave)
      );
      assign bus.m0_req   = m_req[0] & (dsel == (g != 0));
      assign bus.m1_req   = m_req[1] & (dsel == (g != 0));
      assign bus.m0_we    = m_we[0];
      assign bus.m1_we    = m_we[1];
      assign bus.m0_addr  = m_addr[0];
      assign bus.m1_addr  = m_addr[1];
      assign bus.m0_wdata = m_wd[0];
      assign bus.m1_wdata = m_wd[1];
      assign bus.fx_q     = fx_q;
      assign o_ack0[g]  = bus.m0_ack;
      assign o_ack1[g]  = bus.m1_ack;
      assign o_rd0[g]   = bus.m0_rdata;
      assign o_rd1[g]   = bus.m1_rdata;
      assign o_wr[g]    = bus.fx_wr;
      assign o_rd[g]    = bus.fx_rd;
      assign o_waddr[g] = bus.fx_waddr;
      assign o_raddr[g] = bus.fx_raddr;
      assign o_data[g]  = bus.fx_data;
      assign o_busy[g]  = bus.busy;
      assign o_gnt[g]   = bus.gnt;
   end

   assign m0_ack   = o_ack0[dsel];
   assign m1_ack   = o_ack1[dsel];
   assign m0_rdata = o_rd0[dsel];
   assign m1_rdata = o_rd1[dsel];
   assign fx_wr    = o_wr[dsel];
   assign fx_rd    = o_rd[dsel];
   assign fx_waddr = o_waddr[dsel];
   assign fx_raddr = o_raddr[dsel];
   assign fx_data  = o_data[dsel];
   assign busy     = o_busy[dsel];
   assign gnt      = o_gnt[dsel];
   assign acks     = {m1_ack, m0_ack};

   // Slave model: registered read data valid exactly rdlat cycles after the
   // fx_rd cycle; any other cycle presents the bit-inverse as garbage.
   function automatic logic [DW-1:0] slv(input logic [AW-1:0] a);
      return a[7:0] ^ {2'b00, a[21:16]};
   endfunction

   logic [7:0] rd_pipe = 8'h00;
   always @(posedge clk) rd_pipe <= rst ? 8'h00 : {rd_pipe[6:0], fx_rd};
   assign fx_q = rd_pipe[rdlat-1] ? slv(fx_raddr) : ~slv(fx_raddr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: d = write data for writes, expected rdata for reads.
   typedef struct {
      int            m;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] d;
      int            cyc;
   } exp_t;

   exp_t bus_q[$];
   exp_t ack_q[$];

   // c0 = cycle in which the request is sampled in IDLE
   task automatic push(input int m, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int c0);
      exp_t e;
      e.m = m; e.we = we; e.addr = a; e.d = d;
      e.cyc = c0 + 1;
      bus_q.push_back(e);
      e.cyc = we ? c0 + 2 : c0 + 2 + rdlat;
      ack_q.push_back(e);
   endtask

   // Monitor: model of held outputs, checks every strobe and every ack.
   logic [AW-1:0] mdl_waddr = '0, mdl_raddr = '0;
   logic [DW-1:0] mdl_wdata = '0;
   logic [DW-1:0] mdl_rd [2] = '{8'h00, 8'h00};

   initial begin
      exp_t be, ae;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus_q.delete();
            ack_q.delete();
            mdl_waddr = '0; mdl_raddr = '0; mdl_wdata = '0;
            mdl_rd[0] = '0; mdl_rd[1] = '0;
         end else begin
            if (fx_wr || fx_rd) begin
               chk("strobe_overlap", 32'(fx_wr & fx_rd), 32'd0);
               if (bus_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
               else begin
                  be = bus_q.pop_front();
                  chk("strobe_cycle", 32'(cyc), 32'(be.cyc));
                  chk("strobe_we", 32'(fx_wr), 32'(be.we));
                  chk("strobe_gnt", 32'(gnt), 32'(be.m));
                  if (be.we) begin
                     chk("fx_waddr", 32'(fx_waddr), 32'(be.addr));
                     chk("fx_data", 32'(fx_data), 32'(be.d));
                     chk("fx_raddr_hold", 32'(fx_raddr), 32'(mdl_raddr));
                     mdl_waddr = be.addr;
                     mdl_wdata = be.d;
                  end else begin
                     chk("fx_raddr", 32'(fx_raddr), 32'(be.addr));
                     chk("fx_waddr_hold", 32'(fx_waddr), 32'(mdl_waddr));
                     chk("fx_data_hold", 32'(fx_data), 32'(mdl_wdata));
                     mdl_raddr = be.addr;
                  end
               end
            end
            if (m0_ack || m1_ack) begin
               chk("ack_both", 32'(m0_ack & m1_ack), 32'd0);
               if (ack_q.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
               else begin
                  ae = ack_q.pop_front();
                  chk("ack_master", 32'(m1_ack), 32'(ae.m));
                  chk("ack_cycle", 32'(cyc), 32'(ae.cyc));
                  chk("ack_gnt", 32'(gnt), 32'(ae.m));
                  chk("ack_busy", 32'(busy), 32'd1);
                  if (!ae.we) mdl_rd[ae.m] = ae.d;
                  chk("m0_rdata", 32'(m0_rdata), 32'(mdl_rd[0]));
                  chk("m1_rdata", 32'(m1_rdata), 32'(mdl_rd[1]));
               end
            end
         end
      end
   end

   // Master driver: present a transaction, wait for its ack (bounded), then
   // drop req unless keep is set (caller presents the next one immediately).
   task automatic txn(input int m, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit keep);
      int n;
      n = 0;
      m_we[m] = we; m_addr[m] = a; m_wd[m] = d; m_req[m] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!acks[m] && n < 40);
      if (!acks[m]) chk($sformatf("ack_timeout_m%0d", m), 32'd0, 32'd1);
      if (!keep) m_req[m] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      m_req = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, 32'({fx_wr, fx_rd, m0_ack, m1_ack, busy, gnt}), 32'd0);
      chk({tag, "_waddr"}, 32'(fx_waddr), 32'd0);
      chk({tag, "_raddr"}, 32'(fx_raddr), 32'd0);
      chk({tag, "_data"}, 32'(fx_data), 32'd0);
      chk({tag, "_rdata"}, 32'({m0_rdata, m1_rdata}), 32'd0);
   endtask

   initial begin
      int c;
      m_addr[0] = '0; m_addr[1] = '0; m_wd[0] = '0; m_wd[1] = '0;

      // reset state (RD_LAT=1 instance)
      do_reset();
      chk_zero("reset");

      // lone m0 write
      @(negedge clk); c = cyc;
      push(0, 1'b1, 22'h010020, 8'h55, c);
      txn(0, 1'b1, 22'h010020, 8'h55, 1'b0);

      // lone m1 read, slave returns 0x01
      @(negedge clk); c = cyc;
      push(1, 1'b0, 22'h010000, 8'h01, c);
      txn(1, 1'b0, 22'h010000, 8'h00, 1'b0);

      // both request from reset, continuously: 0,1,0,1
      do_reset();
      @(negedge clk); c = cyc;
      push(0, 1'b1, 22'h030001, 8'hA1, c);
      push(1, 1'b1, 22'h040002, 8'hB2, c + 3);
      push(0, 1'b0, 22'h020010, 8'h12, c + 6);
      push(1, 1'b1, 22'h040003, 8'hB3, c + 10);
      fork
         begin
            txn(0, 1'b1, 22'h030001, 8'hA1, 1'b1);
            txn(0, 1'b0, 22'h020010, 8'h00, 1'b0);
         end
         begin
            txn(1, 1'b1, 22'h040002, 8'hB2, 1'b1);
            txn(1, 1'b1, 22'h040003, 8'hB3, 1'b0);
         end
      join

      // m0 raises req during an m1 write; served in the IDLE after m1_ack
      @(negedge clk); c = cyc;
      push(1, 1'b1, 22'h3FFFFF, 8'hFF, c);
      push(0, 1'b1, 22'h050005, 8'h5A, c + 3);
      fork
         txn(1, 1'b1, 22'h3FFFFF, 8'hFF, 1'b0);
         begin
            @(negedge clk);
            txn(0, 1'b1, 22'h050005, 8'h5A, 1'b0);
         end
      join

      // RD_LAT=3 instance
      dsel = 1'b1;
      do_reset();
      @(negedge clk); c = cyc;
      push(0, 1'b0, 22'h0000AA, 8'hAA, c);
      txn(0, 1'b0, 22'h0000AA, 8'h00, 1'b0);
      @(negedge clk); c = cyc;
      push(1, 1'b1, 22'h010020, 8'h66, c);
      txn(1, 1'b1, 22'h010020, 8'h66, 1'b0);

      // reset in the middle of WAIT aborts the read
      @(negedge clk); c = cyc;
      push(0, 1'b0, 22'h0300AB, 8'h00, c);
      m_we[0] = 1'b0; m_addr[0] = 22'h0300AB; m_req[0] = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      m_req[0] = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); c = cyc;
      push(1, 1'b1, 22'h020002, 8'h77, c);
      txn(1, 1'b1, 22'h020002, 8'h77, 1'b0);

      repeat (4) @(negedge clk);
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
